regfile_wb_scheduler: RTL and testbench

- Sequences all writes into the 2-read/1-write register file.
- Arbitrates two writeback sources onto the single write port: src0 (ALU, single-cycle) and src1 (LSU/multicycle, long-latency). Arbitration is round-robin with valid/ready handshakes.
- Keeps a per-register pending scoreboard for long-latency destinations so decode can stall on RAW/WAW hazards.
- Sits between the execute/memory stages and the register file write port; decode reads the busy flags.

---
 rtl/regfile_wb_scheduler_pkg.sv | 18 +
 rtl/regfile_wb_scheduler_if.sv | 39 +++
 rtl/regfile_wb_scheduler_wb_rr_arbiter.sv | 50 +++++
 rtl/regfile_wb_scheduler.sv | 141 ++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
package regfile_wb_scheduler_pkg;

    localparam int REG_NUM        = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int DATA_WIDTH     = 32;

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
    localparam logic RST_ENABLE = 1'b0;
    localparam logic WR_ENABLE  = 1'b1;

    // Writeback source tag carried alongside each accepted write.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Writeback bus: two source request channels plus the register-file write port.
import regfile_wb_scheduler_pkg::*;

interface regfile_wb_scheduler_if #(
    parameter int AW = REG_ADDR_WIDTH,
    parameter int DW = DATA_WIDTH
);
    logic          src0_valid;
    logic [AW-1:0] src0_addr;
    logic [DW-1:0] src0_data;
    logic          src0_ready;

    logic          src1_valid;
    logic [AW-1:0] src1_addr;
    logic [DW-1:0] src1_data;
    logic          src1_ready;

    logic          reg_wr_en;
    logic [AW-1:0] reg_wr_addr;
    logic [DW-1:0] reg_wr_data;

    // Execute/memory side plus register-file observer.
    modport master (
        output src0_valid, src0_addr, src0_data,
        input  src0_ready,
        output src1_valid, src1_addr, src1_data,
        input  src1_ready,
        input  reg_wr_en, reg_wr_addr, reg_wr_data
    );

    // Scheduler side.
    modport slave (
        input  src0_valid, src0_addr, src0_data,
        output src0_ready,
        input  src1_valid, src1_addr, src1_data,
        output src1_ready,
        output reg_wr_en, reg_wr_addr, reg_wr_data
    );
endinterface

// File: rtl/regfile_wb_scheduler_wb_rr_arbiter.sv
// Two-way round-robin arbiter. The priority pointer flips toward the source
// that was not granted, and only moves when a grant (= transfer) happens.
import regfile_wb_scheduler_pkg::*;

module wb_rr_arbiter (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    logic r_prio_src1;

    // Grant selection from requests and the current priority pointer.
    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        case ({i_req1, i_req0})
            2'b01: o_gnt0 = 1'b1;
            2'b10: o_gnt1 = 1'b1;
            2'b11: begin
                if (r_prio_src1) begin
                    o_gnt1 = 1'b1;
                end else begin
                    o_gnt0 = 1'b1;
                end
            end
            default: begin
                o_gnt0 = 1'b0;
                o_gnt1 = 1'b0;
            end
        endcase
    end

    // Priority pointer: favour the other source after every transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            r_prio_src1 <= 1'b0;
        end else if (o_gnt0) begin
            r_prio_src1 <= 1'b1;
        end else if (o_gnt1) begin
            r_prio_src1 <= 1'b0;
        end else begin
            r_prio_src1 <= r_prio_src1;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: arbitrates ALU/LSU writebacks onto the single register
// file write port and tracks outstanding long-latency destinations for decode.
import regfile_wb_scheduler_pkg::*;

module regfile_wb_scheduler #(
    parameter int NUM_REGS = REG_NUM,
    parameter int AW       = REG_ADDR_WIDTH,
    parameter int DW       = DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_en_i,
    input  logic [AW-1:0] issue_rd_i,
    output logic          issue_ready_o,
    input  logic [AW-1:0] rs1_addr_i,
    input  logic [AW-1:0] rs2_addr_i,
    output logic          rs1_busy_o,
    output logic          rs2_busy_o,
    regfile_wb_scheduler_if.slave wb
);

    // One-hot mask selecting a single scoreboard bit.
    function automatic logic [NUM_REGS-1:0] addr_mask(input logic [AW-1:0] a);
        logic [NUM_REGS-1:0] m;
        m    = {NUM_REGS{1'b0}};
        m[a] = 1'b1;
        return m;
    endfunction

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_acc_valid;
    logic [AW-1:0] w_acc_addr;
    logic [DW-1:0] w_acc_data;
    wb_src_e       w_acc_tag;

    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;
    wb_src_e       r_wr_tag;

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_next;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic                w_issue_fire;
    logic                w_retire_lsu;

    wb_rr_arbiter u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_req0 (wb.src0_valid),
        .i_req1 (wb.src1_valid),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    // A grant is only ever given to a valid source, so ready == grant.
    assign wb.src0_ready = w_gnt0;
    assign wb.src1_ready = w_gnt1;

    // Mux the granted request toward the output register.
    always_comb begin
        w_acc_valid = w_gnt0 | w_gnt1;
        w_acc_addr  = {AW{1'b0}};
        w_acc_data  = {DW{1'b0}};
        w_acc_tag   = SRC_ALU;
        if (w_gnt1) begin
            w_acc_addr = wb.src1_addr;
            w_acc_data = wb.src1_data;
            w_acc_tag  = SRC_LSU;
        end else if (w_gnt0) begin
            w_acc_addr = wb.src0_addr;
            w_acc_data = wb.src0_data;
            w_acc_tag  = SRC_ALU;
        end else begin
            w_acc_tag  = SRC_ALU;
        end
    end

    // Output stage: one-cycle write pulse; writes to x0 are swallowed here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= {AW{1'b0}};
            r_wr_data <= {DW{1'b0}};
            r_wr_tag  <= SRC_ALU;
        end else if (w_acc_valid && (w_acc_addr != REG_ZERO)) begin
            r_wr_en   <= WR_ENABLE;
            r_wr_addr <= w_acc_addr;
            r_wr_data <= w_acc_data;
            r_wr_tag  <= w_acc_tag;
        end else begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= {AW{1'b0}};
            r_wr_data <= {DW{1'b0}};
            r_wr_tag  <= SRC_ALU;
        end
    end

    assign wb.reg_wr_en   = r_wr_en;
    assign wb.reg_wr_addr = r_wr_addr;
    assign wb.reg_wr_data = r_wr_data;

    assign w_retire_lsu  = r_wr_en && (r_wr_tag == SRC_LSU);
    assign issue_ready_o = !r_busy[issue_rd_i] || (issue_rd_i == REG_ZERO);
    assign w_issue_fire  = issue_en_i && issue_ready_o && (issue_rd_i != REG_ZERO);

    // Scoreboard next state: clear on LSU retire, then set wins on a new issue.
    always_comb begin
        w_set_mask  = {NUM_REGS{1'b0}};
        w_clr_mask  = {NUM_REGS{1'b0}};
        if (w_issue_fire) begin
            w_set_mask = addr_mask(issue_rd_i);
        end else begin
            w_set_mask = {NUM_REGS{1'b0}};
        end
        if (w_retire_lsu) begin
            w_clr_mask = addr_mask(r_wr_addr);
        end else begin
            w_clr_mask = {NUM_REGS{1'b0}};
        end
        w_busy_next = ((r_busy & ~w_clr_mask) | w_set_mask) & ~addr_mask(REG_ZERO);
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            r_busy <= {NUM_REGS{1'b0}};
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // Busy flags hide the retiring register since the file forwards that write.
    assign rs1_busy_o = r_busy[rs1_addr_i] && (rs1_addr_i != REG_ZERO) &&
                        !(w_retire_lsu && (r_wr_addr == rs1_addr_i));
    assign rs2_busy_o = r_busy[rs2_addr_i] && (rs2_addr_i != REG_ZERO) &&
                        !(w_retire_lsu && (r_wr_addr == rs2_addr_i));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: directed scenarios followed by
// randomized traffic, checked against a behavioural model of the rules.
module tb_regfile_wb_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       issue_en;
    logic [4:0] issue_rd;
    logic       issue_ready;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic       rs1_busy;
    logic       rs2_busy;

    always #5 clk = ~clk;

    regfile_wb_scheduler_if #(.AW(5), .DW(32)) wb_if ();

    regfile_wb_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_en_i    (issue_en),
        .issue_rd_i    (issue_rd),
        .issue_ready_o (issue_ready),
        .rs1_addr_i    (rs1_addr),
        .rs2_addr_i    (rs2_addr),
        .rs1_busy_o    (rs1_busy),
        .rs2_busy_o    (rs2_busy),
        .wb            (wb_if)
    );

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;
    bit  mon_en = 1'b0;

    // Reference model state
    bit [31:0]  m_busy;
    bit         m_last_src0;      // src0 was granted most recently
    bit         m_out_lsu;        // an LSU write sits on the output port this cycle
    logic [4:0] m_out_addr;

    // Stimulus state
    logic        d_v0, d_v1, d_ien;
    logic [4:0]  d_a0, d_a1, d_ird, d_rs1, d_rs2;
    logic [31:0] d_d0, d_d1;
    bit          acc0, acc1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        wb_if.src0_valid = d_v0;
        wb_if.src0_addr  = d_a0;
        wb_if.src0_data  = d_d0;
        wb_if.src1_valid = d_v1;
        wb_if.src1_addr  = d_a1;
        wb_if.src1_data  = d_d1;
        issue_en = d_ien;
        issue_rd = d_ird;
        rs1_addr = d_rs1;
        rs2_addr = d_rs2;
    endtask

    task automatic set_idle();
        d_v0 = 1'b0; d_v1 = 1'b0; d_ien = 1'b0;
        d_ird = 5'd0; d_rs1 = 5'd0; d_rs2 = 5'd0;
    endtask

    task automatic model_reset();
        m_busy      = '0;
        m_last_src0 = 1'b0;
        m_out_lsu   = 1'b0;
        m_out_addr  = 5'd0;
        exp_q.delete();
    endtask

    // One cycle: drive at the falling edge, check combinational outputs,
    // then advance the model to the state after the next rising edge.
    task automatic step();
        bit g0, g1, exp_ir, exp_b1, exp_b2;
        @(negedge clk);
        drive();
        #1;
        g0 = 1'b0; g1 = 1'b0;
        if (d_v0 && d_v1) begin
            if (m_last_src0) g1 = 1'b1; else g0 = 1'b1;
        end else if (d_v0) begin
            g0 = 1'b1;
        end else if (d_v1) begin
            g1 = 1'b1;
        end
        chk("src0_ready", 32'(wb_if.src0_ready), 32'(g0));
        chk("src1_ready", 32'(wb_if.src1_ready), 32'(g1));
        exp_ir = !m_busy[d_ird] || (d_ird == 5'd0);
        exp_b1 = m_busy[d_rs1] && (d_rs1 != 5'd0) && !(m_out_lsu && m_out_addr == d_rs1);
        exp_b2 = m_busy[d_rs2] && (d_rs2 != 5'd0) && !(m_out_lsu && m_out_addr == d_rs2);
        chk("issue_ready", 32'(issue_ready), 32'(exp_ir));
        chk("rs1_busy", 32'(rs1_busy), 32'(exp_b1));
        chk("rs2_busy", 32'(rs2_busy), 32'(exp_b2));
        if (m_out_lsu) m_busy[m_out_addr] = 1'b0;
        if (d_ien && exp_ir && d_ird != 5'd0) m_busy[d_ird] = 1'b1;
        m_out_lsu = 1'b0;
        if (g0) begin
            m_last_src0 = 1'b1;
            if (d_a0 != 5'd0) exp_q.push_back('{d_a0, d_d0});
        end
        if (g1) begin
            m_last_src0 = 1'b0;
            if (d_a1 != 5'd0) begin
                exp_q.push_back('{d_a1, d_d1});
                m_out_lsu  = 1'b1;
                m_out_addr = d_a1;
            end
        end
        acc0 = g0;
        acc1 = g1;
    endtask

    // Monitor: every cycle the write port must match the next expected write.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_en", 32'(wb_if.reg_wr_en), 32'd1);
                chk("wr_addr", 32'(wb_if.reg_wr_addr), 32'(mon_e.addr));
                chk("wr_data", wb_if.reg_wr_data, mon_e.data);
            end else begin
                chk("wr_en_idle", 32'(wb_if.reg_wr_en), 32'd0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        d_a0 = 5'd0; d_a1 = 5'd0; d_d0 = 32'd0; d_d1 = 32'd0;
        set_idle();
        drive();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(wb_if.reg_wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wb_if.reg_wr_addr), 32'd0);
        chk("rst_wr_data", wb_if.reg_wr_data, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single ALU write
        set_idle();
        d_v0 = 1'b1; d_a0 = 5'd3; d_d0 = 32'hAAAA_0001;
        step();
        set_idle();
        step();

        // RAW hazard on x7 and its retirement
        d_ien = 1'b1; d_ird = 5'd7;
        step();
        set_idle(); d_ird = 5'd7; d_rs1 = 5'd7;
        step();
        d_v1 = 1'b1; d_a1 = 5'd7; d_d1 = 32'h0000_7777;
        step();
        set_idle(); d_rs1 = 5'd7; d_rs2 = 5'd7;
        step();
        step();

        // Retire and reissue the same register in one cycle: set wins
        set_idle(); d_v1 = 1'b1; d_a1 = 5'd9; d_d1 = 32'h0000_9999;
        step();
        set_idle(); d_ien = 1'b1; d_ird = 5'd9; d_rs1 = 5'd9;
        step();
        set_idle(); d_rs1 = 5'd9; d_ird = 5'd9;
        step();

        // x0 handling
        set_idle(); d_v1 = 1'b1; d_a1 = 5'd0; d_d1 = 32'hFFFF_FFFF;
        step();
        set_idle(); d_ien = 1'b1; d_ird = 5'd0;
        step();
        set_idle();
        step();

        // Reset while a write is in flight and x5 is busy
        set_idle(); d_ien = 1'b1; d_ird = 5'd5; d_v0 = 1'b1; d_a0 = 5'd12; d_d0 = 32'h1234_5678;
        step();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        set_idle();
        drive();
        #1;
        chk("arst_wr_en", 32'(wb_if.reg_wr_en), 32'd0);
        chk("arst_wr_addr", 32'(wb_if.reg_wr_addr), 32'd0);
        chk("arst_wr_data", wb_if.reg_wr_data, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Contention after reset: src0 first, then alternate
        for (int i = 0; i < 4; i++) begin
            if (i == 0 || acc0) begin d_a0 = 5'd1; d_d0 = 32'h1000_0000 + 32'(i); end
            if (i == 0 || acc1) begin d_a1 = 5'd2; d_d1 = 32'h2000_0000 + 32'(i); end
            d_v0 = 1'b1; d_v1 = 1'b1; d_rs1 = 5'd5; d_rs2 = 5'd0;
            step();
        end

        // Random traffic; unaccepted requests are held stable
        for (int n = 0; n < 2000; n++) begin
            if (!d_v0 || acc0) begin
                d_v0 = ($urandom_range(0, 1) == 1);
                d_a0 = 5'($urandom_range(0, 15));
                d_d0 = $urandom;
            end
            if (!d_v1 || acc1) begin
                d_v1 = ($urandom_range(0, 2) == 0);
                d_a1 = 5'($urandom_range(0, 15));
                d_d1 = $urandom;
            end
            d_ien = ($urandom_range(0, 3) == 0);
            d_ird = 5'($urandom_range(0, 15));
            d_rs1 = 5'($urandom_range(0, 15));
            d_rs2 = 5'($urandom_range(0, 15));
            step();
        end

        // Drain: let any held request through, then go idle
        while (d_v0 || d_v1) begin
            if (acc0) d_v0 = 1'b0;
            if (acc1) d_v1 = 1'b0;
            d_ien = 1'b0;
            if (d_v0 || d_v1) step();
        end
        set_idle();
        repeat (3) step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
